prg_loader: RTL and testbench
=============================

PRG_LOADER -- requirements
Module: prg_loader

Interface
REQ-001 Parameter INJECT_EN, default 1, meaning: 1 = write BASIC end pointers after load, 0 = skip injection.
REQ-002 clk_sys  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 dl_active  input  1  PRG download in progress, level, synchronous to clk_sys.
REQ-005 dl_wr  input  1  one-cycle strobe: dl_addr/dl_data valid.
REQ-006 dl_addr  input  16  byte offset within the PRG file.
REQ-007 dl_data  input  8  file byte.
REQ-008 wr_req  output  1  memory write request, held until acknowledged.
REQ-009 wr_addr  output  16  target address; stable while wr_req=1.
REQ-010 wr_data  output  8  target data; stable while wr_req=1.
REQ-011 wr_int  output  1  1 = target is internal block RAM, 0 = SDRAM; stable while wr_req=1.
REQ-012 wr_ack  input  1  one-cycle acknowledge; completes the pending request.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at end of load sequence.
REQ-015 err  output  1  sticky error flag.

Function
REQ-016 States: IDLE, LOAD, DRAIN, INJECT, FIN; encoding is implementation-defined.
REQ-017 IDLE->LOAD on dl_active=1; on entry, clear load pointer, header count, and err.
REQ-018 In LOAD, dl_wr with dl_addr=0 sets pointer[7:0]=dl_data; dl_addr=1 sets pointer[15:8]=dl_data; neither generates a write.
REQ-019 In LOAD, dl_wr with dl_addr>=2 loads request register {pointer, dl_data}, asserts wr_req next cycle, and increments pointer by 1 (16-bit wrap FFFF->0000).
REQ-020 wr_int=1 when wr_addr is in 0000-03FF, 1000-1FFF, or 9400-97FF; otherwise 0.
REQ-021 wr_ack is honoured only while wr_req=1; wr_req falls the cycle after wr_ack unless a new byte is accepted in the same cycle, in which case wr_req stays high with the new address/data.
REQ-022 dl_wr (addr>=2) while wr_req=1 and wr_ack=0: byte dropped, pointer not incremented, err set.
REQ-023 LOAD->DRAIN on dl_active=0; DRAIN waits until wr_req=0.
REQ-024 DRAIN->INJECT when both header bytes were received and INJECT_EN=1; otherwise DRAIN->FIN, and if the header is incomplete, err is set.
REQ-025 INJECT issues 8 sequential requests, each waiting for wr_ack: addresses 002D,002E,002F,0030,0031,0032,00AE,00AF; data alternates pointer[7:0], pointer[15:8], starting with low; wr_int=1 for all.
REQ-026 The injected pointer value is the final pointer (load address + data byte count).
REQ-027 After the 8th ack: INJECT->FIN; FIN asserts done for exactly 1 cycle, then returns to IDLE.
REQ-028 dl_wr received in DRAIN, INJECT, or FIN: ignored, and err set; dl_active=1 in these states does not restart the load.
REQ-029 wr_ack while wr_req=0: ignored.

Reset
REQ-030 reset_n=0 forces IDLE immediately: wr_req=0, done=0, busy=0, err=0, wr_addr=0, wr_data=0, wr_int=0, pointer=0; a mid-operation request is abandoned.
REQ-031 Leaving reset with dl_active=1 enters LOAD on the first clock edge.

Verification
REQ-032 File bytes 01 10 AA BB, ack 2 cycles after each req -> writes 1001/AA wr_int=1, 1002/BB wr_int=1; inject 2D=03, 2E=10, 2F=03, 30=10, 31=03, 32=10, AE=03, AF=10; one done pulse; err=0.
REQ-033 Header 00 A0, bytes 55 at back-to-back dl_wr with wr_ack held 0 for 3 cycles -> 2nd byte dropped, err=1, injected pointer A001.
REQ-034 Header FF FF, 2 data bytes -> writes FFFF then 0000 (wrap, wr_int=1 for 0000); injected pointer 0001.
REQ-035 dl_active falls after 1 byte -> no writes, no injection, done pulse, err=1; with INJECT_EN=0 and valid file -> no writes to 002D-00AF.
REQ-036 reset_n low during INJECT (3rd request pending) -> wr_req=0, busy=0 asynchronously; no done pulse; next download behaves per REQ-032.

Source files
------------

// File: rtl/prg_loader.sv
// PRG file loader: strips the 2-byte load-address header and streams the
// remaining file bytes into memory through a single-entry request register.
// Once the download ends it can write the BASIC end pointers, so a
// loaded program can be RUN straight away.
module prg_loader #(
    parameter int unsigned INJECT_EN = 1
) (
    input  logic        clk_sys_i,
    input  logic        reset_n_i,
    input  logic        dl_active_i,
    input  logic        dl_wr_i,
    input  logic [15:0] dl_addr_i,
    input  logic [7:0]  dl_data_i,
    output logic        wr_req_o,
    output logic [15:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        wr_int_o,
    input  logic        wr_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StInject,
        StFin
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [1:0]  hdr_q, hdr_d;     // bit0: low header byte seen, bit1: high byte seen
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        int_q, int_d;
    logic [2:0]  idx_q, idx_d;     // index of the pointer write being issued
    logic        ack_fire;
    logic        done;

    // Internal block RAM windows: 0000-03FF, 1000-1FFF, 9400-97FF.
    function automatic logic is_int(input logic [15:0] a);
        return (a[15:10] == 6'b000000) || (a[15:12] == 4'b0001) || (a[15:10] == 6'b100101);
    endfunction

    // BASIC end-pointer locations, written low byte first in pairs.
    function automatic logic [15:0] inj_addr(input logic [2:0] idx);
        logic [15:0] a;
        a = 16'h0000;
        unique case (idx)
            3'd0: a = 16'h002D;
            3'd1: a = 16'h002E;
            3'd2: a = 16'h002F;
            3'd3: a = 16'h0030;
            3'd4: a = 16'h0031;
            3'd5: a = 16'h0032;
            3'd6: a = 16'h00AE;
            3'd7: a = 16'h00AF;
        endcase
        return a;
    endfunction

    // Acks only count while a request is actually outstanding.
    assign ack_fire = wr_ack_i & req_q;

    // Next-state logic for the load sequence and the request register.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hdr_d   = hdr_q;
        err_d   = err_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        int_d   = int_q;
        idx_d   = idx_q;
        done    = 1'b0;

        if (ack_fire) begin
            req_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (dl_active_i) begin
                    state_d = StLoad;
                    ptr_d   = 16'h0000;
                    hdr_d   = 2'b00;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (dl_wr_i) begin
                    if (dl_addr_i == 16'd0) begin
                        ptr_d[7:0] = dl_data_i;
                        hdr_d[0]   = 1'b1;
                    end else if (dl_addr_i == 16'd1) begin
                        ptr_d[15:8] = dl_data_i;
                        hdr_d[1]    = 1'b1;
                    end else if (!req_q || ack_fire) begin
                        // Slot free (or freeing this cycle): take the byte.
                        req_d  = 1'b1;
                        addr_d = ptr_q;
                        data_d = dl_data_i;
                        int_d  = is_int(ptr_q);
                        ptr_d  = ptr_q + 16'd1;
                    end else begin
                        // Memory still busy with the previous byte: drop it.
                        err_d = 1'b1;
                    end
                end
                if (!dl_active_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (dl_wr_i) begin
                    err_d = 1'b1;
                end
                if (!req_q) begin
                    if ((hdr_q == 2'b11) && (INJECT_EN != 0)) begin
                        state_d = StInject;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = StFin;
                        if (hdr_q != 2'b11) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            StInject: begin
                if (dl_wr_i) begin
                    err_d = 1'b1;
                end
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = inj_addr(idx_q);
                    data_d = idx_q[0] ? ptr_q[15:8] : ptr_q[7:0];
                    int_d  = 1'b1;
                end else if (ack_fire) begin
                    if (idx_q == 3'd7) begin
                        state_d = StFin;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StFin: begin
                if (dl_wr_i) begin
                    err_d = 1'b1;
                end
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and request registers; reset abandons any pending request.
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            ptr_q   <= 16'h0000;
            hdr_q   <= 2'b00;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= 16'h0000;
            data_q  <= 8'h00;
            int_q   <= 1'b0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hdr_q   <= hdr_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            int_q   <= int_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs come straight from registers or the decoded state.
    always_comb begin
        wr_req_o  = req_q;
        wr_addr_o = addr_q;
        wr_data_o = data_q;
        wr_int_o  = int_q;
        busy_o    = (state_q != StIdle);
        done_o    = done;
        err_o     = err_q;
    end

endmodule

// File: tb/tb_prg_loader.sv
// Bench for prg_loader: drives PRG downloads, acks memory writes with a
// programmable delay, and compares every completed write against a
// reference model built from the file contents.
module tb_prg_loader;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        i;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dl_active, dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        wr_req, wr_int, wr_ack, busy, done, err;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_req2, wr_int2, wr_ack2, busy2, done2, err2;
    logic [15:0] wr_addr2;
    logic [7:0]  wr_data2;

    int  pass_cnt = 0;
    int  total_cnt = 0;
    int  done_cnt = 0;
    int  done2_cnt = 0;
    int  ack_delay = 0;
    bit  auto_ack = 1'b1;
    bit  exp_err;
    logic [7:0] file_q[$];
    wr_t act_q[$];
    wr_t act2_q[$];
    wr_t exp_q[$];
    logic [15:0] inj_tbl [8] = '{16'h002D, 16'h002E, 16'h002F, 16'h0030,
                                 16'h0031, 16'h0032, 16'h00AE, 16'h00AF};

    always #5 clk = ~clk;

    prg_loader #(.INJECT_EN(1)) u_dut (
        .clk_sys_i(clk), .reset_n_i(reset_n), .dl_active_i(dl_active), .dl_wr_i(dl_wr),
        .dl_addr_i(dl_addr), .dl_data_i(dl_data), .wr_req_o(wr_req), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .wr_int_o(wr_int), .wr_ack_i(wr_ack), .busy_o(busy),
        .done_o(done), .err_o(err)
    );

    prg_loader #(.INJECT_EN(0)) u_dut_noinj (
        .clk_sys_i(clk), .reset_n_i(reset_n), .dl_active_i(dl_active), .dl_wr_i(dl_wr),
        .dl_addr_i(dl_addr), .dl_data_i(dl_data), .wr_req_o(wr_req2), .wr_addr_o(wr_addr2),
        .wr_data_o(wr_data2), .wr_int_o(wr_int2), .wr_ack_i(wr_ack2), .busy_o(busy2),
        .done_o(done2), .err_o(err2)
    );

    // Memory responder for the main instance: ack after ack_delay waiting cycles.
    initial begin
        int wait_cnt;
        wr_ack = 1'b0;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            wr_ack = 1'b0;
            if (reset_n && auto_ack && wr_req) begin
                if (wait_cnt >= ack_delay) begin
                    wr_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // The no-injection instance is acked as fast as possible.
    initial begin
        wr_ack2 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            wr_ack2 = wr_req2;
        end
    end

    // Record completed writes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_req && wr_ack) act_q.push_back('{a: wr_addr, d: wr_data, i: wr_int});
            if (wr_req2 && wr_ack2) act2_q.push_back('{a: wr_addr2, d: wr_data2, i: wr_int2});
            if (done) done_cnt++;
            if (done2) done2_cnt++;
        end
    end

    function automatic logic in_int(input logic [15:0] a);
        return (a <= 16'h03FF) || (a >= 16'h1000 && a <= 16'h1FFF) ||
               (a >= 16'h9400 && a <= 16'h97FF);
    endfunction

    // Reference: every data byte lands at load+offset, then (optionally) the
    // final pointer is written to each BASIC pointer location.
    function automatic void build_model(input bit inj);
        logic [15:0] load, fin;
        exp_q.delete();
        exp_err = (file_q.size() < 2);
        if (exp_err) return;
        load = {file_q[1], file_q[0]};
        for (int k = 2; k < file_q.size(); k++) begin
            logic [15:0] wa;
            wa = load + 16'(k - 2);
            exp_q.push_back('{a: wa, d: file_q[k], i: in_int(wa)});
        end
        if (inj) begin
            fin = load + 16'(file_q.size() - 2);
            for (int j = 0; j < 8; j++)
                exp_q.push_back('{a: inj_tbl[j], d: (j % 2 == 1) ? fin[15:8] : fin[7:0], i: 1'b1});
        end
    endfunction

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
        dl_wr = 1'b1;
        dl_addr = a;
        dl_data = d;
        @(posedge clk);
        #1;
        dl_wr = 1'b0;
    endtask

    // Plays file_q as a download; spaced waits for the write slot to free up.
    task automatic run_file(input bit spaced, output bit ok);
        bit idle;
        ok = 1'b1;
        dl_active = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < file_q.size(); k++) begin
            if (spaced && k >= 2) begin
                bit freed;
                freed = 1'b0;
                for (int w = 0; w < 100; w++) begin
                    if (!wr_req) begin
                        freed = 1'b1;
                        break;
                    end
                    @(posedge clk);
                    #1;
                end
                if (!freed) ok = 1'b0;
            end
            send_byte(16'(k), file_q[k]);
        end
        dl_active = 1'b0;
        idle = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) ok = 1'b0;
    endtask

    task automatic test_reset;
        int d0;
        bit idle;
        reset_n = 1'b0;
        dl_active = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (wr_req !== 1'b0) $display("FAIL reset_wr_req: got %b want 0", wr_req); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
        total_cnt++; if (wr_addr !== 16'h0) $display("FAIL reset_wr_addr: got %h want 0000", wr_addr); else pass_cnt++;
        total_cnt++; if (wr_data !== 8'h0) $display("FAIL reset_wr_data: got %h want 00", wr_data); else pass_cnt++;
        total_cnt++; if (wr_int !== 1'b0) $display("FAIL reset_wr_int: got %b want 0", wr_int); else pass_cnt++;
        d0 = done_cnt;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL reset_exit_load: busy %b want 1", busy); else pass_cnt++;
        dl_active = 1'b0;
        idle = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        total_cnt++; if (!idle) $display("FAIL reset_exit_idle: busy stuck got 1 want 0"); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL reset_exit_hdr_err: got %b want 1", err); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 != 1) $display("FAIL reset_exit_done: got %0d pulses want 1", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_basic(input string nm);
        bit ok;
        int d0;
        file_q = '{8'h01, 8'h10, 8'hAA, 8'hBB};
        ack_delay = 2;
        auto_ack = 1'b1;
        act_q.delete();
        d0 = done_cnt;
        run_file(1'b1, ok);
        build_model(1'b1);
        total_cnt++; if (!ok) $display("FAIL %s_timeout: got timeout want completion", nm); else pass_cnt++;
        total_cnt++; if (act_q.size() != exp_q.size()) $display("FAIL %s_count: got %0d want %0d", nm, act_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i]) $display("FAIL %s_wr[%0d]: got %h/%h/%b want %h/%h/%b", nm, i, act_q[i].a, act_q[i].d, act_q[i].i, exp_q[i].a, exp_q[i].d, exp_q[i].i);
            else pass_cnt++;
        end
        total_cnt++; if (err !== 1'b0) $display("FAIL %s_err: got %b want 0", nm, err); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 != 1) $display("FAIL %s_done: got %0d pulses want 1", nm, done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_overrun;
        bit idle;
        int d0;
        auto_ack = 1'b0;
        act_q.delete();
        d0 = done_cnt;
        dl_active = 1'b1;
        @(posedge clk);
        #1;
        send_byte(16'd0, 8'h00);
        send_byte(16'd1, 8'hA0);
        send_byte(16'd2, 8'h55);
        send_byte(16'd3, 8'h66);
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (err !== 1'b1) $display("FAIL overrun_err: got %b want 1", err); else pass_cnt++;
        total_cnt++; if ({wr_req, wr_addr, wr_data} !== {1'b1, 16'hA000, 8'h55}) $display("FAIL overrun_hold: got %b/%h/%h want 1/a000/55", wr_req, wr_addr, wr_data); else pass_cnt++;
        auto_ack = 1'b1;
        ack_delay = 0;
        dl_active = 1'b0;
        idle = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        total_cnt++; if (!idle) $display("FAIL overrun_timeout: got timeout want completion"); else pass_cnt++;
        // Only the first data byte survives, so the final pointer is A001.
        file_q = '{8'h00, 8'hA0, 8'h55};
        build_model(1'b1);
        total_cnt++; if (act_q.size() != exp_q.size()) $display("FAIL overrun_count: got %0d want %0d", act_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i]) $display("FAIL overrun_wr[%0d]: got %h/%h/%b want %h/%h/%b", i, act_q[i].a, act_q[i].d, act_q[i].i, exp_q[i].a, exp_q[i].d, exp_q[i].i);
            else pass_cnt++;
        end
        total_cnt++; if (err !== 1'b1) $display("FAIL overrun_err_sticky: got %b want 1", err); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 != 1) $display("FAIL overrun_done: got %0d pulses want 1", done_cnt - d0); else pass_cnt++;
    endtask

    // Plays file_q with the given spacing and checks writes, err and done.
    task automatic test_file(input string nm, input bit spaced);
        bit ok;
        int d0;
        act_q.delete();
        d0 = done_cnt;
        run_file(spaced, ok);
        build_model(1'b1);
        total_cnt++; if (!ok) $display("FAIL %s_timeout: got timeout want completion", nm); else pass_cnt++;
        total_cnt++; if (act_q.size() != exp_q.size()) $display("FAIL %s_count: got %0d want %0d", nm, act_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i]) $display("FAIL %s_wr[%0d]: got %h/%h/%b want %h/%h/%b", nm, i, act_q[i].a, act_q[i].d, act_q[i].i, exp_q[i].a, exp_q[i].d, exp_q[i].i);
            else pass_cnt++;
        end
        total_cnt++; if (err !== exp_err) $display("FAIL %s_err: got %b want %b", nm, err, exp_err); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 != 1) $display("FAIL %s_done: got %0d pulses want 1", nm, done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        file_q = '{8'h34, 8'h12};
        for (int k = 0; k < 4; k++) file_q.push_back(8'($urandom));
        ack_delay = 0;
        test_file("b2b", 1'b0);
    endtask

    task automatic test_wrap;
        file_q = '{8'hFF, 8'hFF, 8'($urandom), 8'($urandom)};
        ack_delay = $urandom_range(0, 3);
        test_file("wrap", 1'b1);
    endtask

    task automatic test_short;
        file_q = '{8'($urandom)};
        ack_delay = 1;
        test_file("short", 1'b1);
    endtask

    task automatic test_noinject;
        bit ok;
        int d2, hits;
        file_q = '{8'h00, 8'hC0, 8'($urandom), 8'($urandom), 8'($urandom)};
        ack_delay = 1;
        act_q.delete();
        act2_q.delete();
        d2 = done2_cnt;
        run_file(1'b1, ok);
        build_model(1'b0);
        total_cnt++; if (!ok) $display("FAIL noinj_timeout: got timeout want completion"); else pass_cnt++;
        total_cnt++; if (act2_q.size() != exp_q.size()) $display("FAIL noinj_count: got %0d want %0d", act2_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < act2_q.size(); i++) begin
            total_cnt++;
            if (act2_q[i] !== exp_q[i]) $display("FAIL noinj_wr[%0d]: got %h/%h/%b want %h/%h/%b", i, act2_q[i].a, act2_q[i].d, act2_q[i].i, exp_q[i].a, exp_q[i].d, exp_q[i].i);
            else pass_cnt++;
        end
        hits = 0;
        foreach (act2_q[i]) if (act2_q[i].a >= 16'h002D && act2_q[i].a <= 16'h00AF) hits++;
        total_cnt++; if (hits != 0) $display("FAIL noinj_ptr_writes: got %0d want 0", hits); else pass_cnt++;
        total_cnt++; if (err2 !== 1'b0) $display("FAIL noinj_err: got %b want 0", err2); else pass_cnt++;
        total_cnt++; if (busy2 !== 1'b0) $display("FAIL noinj_busy: got %b want 0", busy2); else pass_cnt++;
        total_cnt++; if (done2_cnt - d2 != 1) $display("FAIL noinj_done: got %0d pulses want 1", done2_cnt - d2); else pass_cnt++;
        build_model(1'b1);
        total_cnt++; if (act_q.size() != exp_q.size()) $display("FAIL noinj_main_count: got %0d want %0d", act_q.size(), exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_random;
        bit spaced;
        for (int it = 0; it < 6; it++) begin
            int n;
            file_q = '{8'($urandom), 8'($urandom)};
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) file_q.push_back(8'($urandom));
            ack_delay = $urandom_range(0, 3);
            spaced = (ack_delay == 0) ? 1'($urandom) : 1'b1;
            test_file("rand", spaced);
        end
    endtask

    task automatic test_reset_inject;
        bit hit, seen;
        int d0;
        file_q = '{8'h00, 8'h20, 8'h11, 8'h22};
        ack_delay = 3;
        dl_active = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < file_q.size(); k++) begin
            for (int w = 0; w < 50 && wr_req; w++) begin
                @(posedge clk);
                #1;
            end
            send_byte(16'(k), file_q[k]);
        end
        dl_active = 1'b0;
        hit = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (wr_req && wr_addr == 16'h002F) begin
                hit = 1'b1;
                break;
            end
            if (!seen && wr_req && wr_addr == 16'h002D) begin
                // A stray byte mid-injection must flag err without restarting.
                seen = 1'b1;
                dl_active = 1'b1;
                send_byte(16'h0005, 8'h77);
                dl_active = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        total_cnt++; if (!hit) $display("FAIL rstinj_reach: got timeout want 3rd pointer write"); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL rstinj_stray_err: got %b want 1", err); else pass_cnt++;
        d0 = done_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (wr_req !== 1'b0) $display("FAIL rstinj_wr_req: got %b want 0", wr_req); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstinj_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (wr_addr !== 16'h0) $display("FAIL rstinj_wr_addr: got %h want 0000", wr_addr); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (done_cnt != d0) $display("FAIL rstinj_no_done: got %0d pulses want 0", done_cnt - d0); else pass_cnt++;
        test_basic("after_rst");
    endtask

    initial begin
        reset_n = 1'b0;
        dl_active = 1'b0;
        dl_wr = 1'b0;
        dl_addr = 16'h0;
        dl_data = 8'h0;
        test_reset();
        test_basic("basic");
        test_overrun();
        test_back_to_back();
        test_wrap();
        test_short();
        test_noinject();
        test_random();
        test_reset_inject();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
